// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch queue between Fetch and Decode.
package fetch_queue_pkg;

    localparam int unsigned FETCHQ_DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } fetch_entry_t;

    // Limit a requested pop count to the number of entries actually presented.
    function automatic logic [1:0] clamp_take(input logic [1:0] take, input logic [1:0] avail);
        return (take > avail) ? avail : take;
    endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage: two synchronous write ports, two asynchronous read ports, no reset.
module fetchq_ram
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FETCHQ_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we_1,
    input  logic [PTR_W-1:0]   waddr_1,
    input  fetch_entry_t       wdata_1,
    input  logic               we_2,
    input  logic [PTR_W-1:0]   waddr_2,
    input  fetch_entry_t       wdata_2,
    input  logic [PTR_W-1:0]   raddr_1,
    output fetch_entry_t       rdata_1,
    input  logic [PTR_W-1:0]   raddr_2,
    output fetch_entry_t       rdata_2
);

    fetch_entry_t mem [DEPTH];

    // Write both slots; the top always presents distinct addresses (tail, tail+1).
    always_ff @(posedge clk) begin
        if (we_1) mem[waddr_1] <= wdata_1;
        if (we_2) mem[waddr_2] <= wdata_2;
    end

    // Combinational read of head and head+1.
    always_comb begin
        rdata_1 = mem[raddr_1];
        rdata_2 = mem[raddr_2];
    end

endmodule

// File: rtl/fetch_queue.sv
// Dual-issue instruction queue decoupling Fetch from Decode; squashed on redirect.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FETCHQ_DEPTH
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        in_valid_1,
    input  logic        in_valid_2,
    input  logic [31:0] in_pc_1,
    input  logic [31:0] in_pc_2,
    input  logic [31:0] in_instr_1,
    input  logic [31:0] in_instr_2,
    input  logic        in_adel_1,
    input  logic        in_adel_2,
    output logic        in_ready,
    output logic        out_valid_1,
    output logic        out_valid_2,
    output logic [31:0] out_pc_1,
    output logic [31:0] out_pc_2,
    output logic [31:0] out_instr_1,
    output logic [31:0] out_instr_2,
    output logic        out_adel_1,
    output logic        out_adel_2,
    input  logic [1:0]  out_take
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             push;
    logic [1:0]       pushed;
    logic [1:0]       avail;
    logic [1:0]       taken;
    logic             we_1;
    logic             we_2;
    fetch_entry_t     wdata_1;
    fetch_entry_t     wdata_2;
    fetch_entry_t     rdata_1;
    fetch_entry_t     rdata_2;

    // Ready, push/pop amounts and output valids, all from registered count only.
    always_comb begin
        in_ready    = (count <= CNT_W'(DEPTH - 2));
        push        = in_ready & in_valid_1;
        pushed      = push ? (in_valid_2 ? 2'd2 : 2'd1) : 2'd0;
        avail       = (count >= CNT_W'(2)) ? 2'd2 : count[1:0];
        taken       = clamp_take(out_take, avail);
        out_valid_1 = (count != '0);
        out_valid_2 = (count >= CNT_W'(2));
        // Writes during flush/reset are harmless but suppressed to keep the array quiet.
        we_1        = push & resetn & ~flush;
        we_2        = we_1 & in_valid_2;
        wdata_1     = '{pc: in_pc_1, instr: in_instr_1, adel: in_adel_1};
        wdata_2     = '{pc: in_pc_2, instr: in_instr_2, adel: in_adel_2};
    end

    // Pointer and count update; flush and reset both empty the queue.
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(taken);
            tail  <= tail + PTR_W'(pushed);
            count <= count + CNT_W'(pushed) - CNT_W'(taken);
        end
    end

    // Protocol checks on Decode's take count and Fetch's slot ordering.
    always_ff @(posedge clk) begin
        if (resetn) begin
            assert (out_take <= avail);
            assert (in_valid_1 || !in_valid_2);
        end
    end

    fetchq_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_1    (we_1),
        .waddr_1 (tail),
        .wdata_1 (wdata_1),
        .we_2    (we_2),
        .waddr_2 (tail + PTR_W'(1)),
        .wdata_2 (wdata_2),
        .raddr_1 (head),
        .rdata_1 (rdata_1),
        .raddr_2 (head + PTR_W'(1)),
        .rdata_2 (rdata_2)
    );

    // Payloads come straight from the array; they are don't-care when invalid.
    always_comb begin
        out_pc_1    = rdata_1.pc;
        out_instr_1 = rdata_1.instr;
        out_adel_1  = rdata_1.adel;
        out_pc_2    = rdata_2.pc;
        out_instr_2 = rdata_2.instr;
        out_adel_2  = rdata_2.adel;
    end

endmodule
